// File: rtl/npu_fifo_pkg.sv
// Shared definitions for the NPU stream FIFO: read-mode encodings and
// the occupancy counter width helper.
package npu_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Bits needed to hold every occupancy value 0..depth inclusive.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/npu_fifo_mem.sv
// Simple dual-port register array: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module npu_fifo_mem #(
    parameter int WIDTH  = 17,
    parameter int DEPTH  = 12,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: store the word at the write address when enabled.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/npu_stream_fifo.sv
// Parametrised synchronous FIFO between the NPU controller and the
// systolic array. Supports registered-read and first-word-fall-through
// modes, occupancy/threshold flags, flush and sticky error flags.
module npu_stream_fifo
    import npu_fifo_pkg::*;
#(
    parameter int N         = 2,
    parameter int M         = 3,
    parameter int WIDTH     = 15 + N,
    parameter int DEPTH     = 2 * N * M,
    parameter int FWFT      = FIFO_MODE_STD,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              din,
    input  logic                          rd_en,
    input  logic                          flush,
    output logic [WIDTH-1:0]              dout,
    output logic                          dout_valid,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [fifo_cnt_w(DEPTH)-1:0]  count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int CW = fifo_cnt_w(DEPTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
    localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);
    localparam logic [CW-1:0] C_CONE  = CW'(1);
    localparam logic [PW-1:0] C_LAST  = PW'(DEPTH - 1);
    localparam logic [PW-1:0] C_PONE  = PW'(1);

    // Reject illegal geometries and thresholds at elaboration.
    generate
        if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
            AE_THRESH < 0 || AE_THRESH > DEPTH - 1 ||
            (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT)) begin : g_bad_params
            $error("npu_stream_fifo: illegal DEPTH/threshold/FWFT parameters");
        end
    endgenerate

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_mem_we;
    logic [WIDTH-1:0] w_rdata;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] p);
        return (p == C_LAST) ? '0 : p + C_PONE;
    endfunction

    // Flags decode straight from the registered count, so they settle in
    // the cycle after the accepting edge with no extra lag.
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == C_DEPTH);
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (r_count <= C_AE);
    assign almost_full  = (r_count >= C_AF);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A full FIFO never passes data through, even with a pop in the same
    // cycle; flush suppresses both requests.
    assign w_push_ok = wr_en & ~w_full  & ~flush;
    assign w_pop_ok  = rd_en & ~w_empty & ~flush;
    assign w_mem_we  = w_push_ok & ~rst;

    npu_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (PW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (din),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // Pointer, occupancy and sticky error bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + C_CONE;
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - C_CONE;
            end
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT == FIFO_MODE_STD) begin : g_std
            logic [WIDTH-1:0] r_dout;
            logic             r_dout_valid;

            // Registered read: capture the head on each pop, pulse valid once.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dout       <= '0;
                    r_dout_valid <= 1'b0;
                end else if (flush) begin
                    r_dout_valid <= 1'b0;
                end else begin
                    r_dout_valid <= w_pop_ok;
                    if (w_pop_ok) begin
                        r_dout <= w_rdata;
                    end
                end
            end

            assign dout       = r_dout;
            assign dout_valid = r_dout_valid;
        end else begin : g_fwft
            // Head is always presented; gated to zero so an empty FIFO never
            // shows stale or uninitialised memory.
            assign dout       = w_empty ? '0 : w_rdata;
            assign dout_valid = ~w_empty;
        end
    endgenerate

endmodule

// File: tb/tb_npu_stream_fifo.sv
// Directed bench for npu_stream_fifo: one registered-read instance and one
// FWFT instance driven by the same stimulus.
module tb_npu_stream_fifo;

    localparam int W  = 17;
    localparam int D  = 12;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, wr_en, rd_en, flush;
    logic [W-1:0]  din;

    logic [W-1:0]  s_dout, f_dout;
    logic          s_dv, s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
    logic          f_dv, f_empty, f_full, f_ae, f_af, f_ovf, f_udf;
    logic [CW-1:0] s_count, f_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    npu_stream_fifo #(.FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .flush(flush), .dout(s_dout), .dout_valid(s_dv), .empty(s_empty),
        .full(s_full), .almost_empty(s_ae), .almost_full(s_af),
        .count(s_count), .overflow(s_ovf), .underflow(s_udf)
    );

    npu_stream_fifo #(.FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .flush(flush), .dout(f_dout), .dout_valid(f_dv), .empty(f_empty),
        .full(f_full), .almost_empty(f_ae), .almost_full(f_af),
        .count(f_count), .overflow(f_ovf), .underflow(f_udf)
    );

    typedef struct {
        bit           wr;
        bit           rd;
        bit           fl;
        logic [W-1:0] din;
        logic [W-1:0] e_dout;
        bit           e_dv;
        int           e_cnt;
        bit           e_empty;
        bit           e_ae;
        bit           e_udf;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; rst = 1'b0;
    endtask

    logic [W-1:0] q[$];
    logic [W-1:0] e;

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; din = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_count", s_count, 0);
        chk("rst_empty", s_empty, 1);
        chk("rst_full", s_full, 0);
        chk("rst_ae", s_ae, 1);
        chk("rst_af", s_af, 0);
        chk("rst_dout", s_dout, 0);
        chk("rst_dv", s_dv, 0);
        chk("rst_ovf", s_ovf, 0);
        chk("rst_udf", s_udf, 0);
        chk("rst_f_dv", f_dv, 0);
        chk("rst_f_dout", f_dout, 0);

        // wr rd fl din | dout dv cnt empty ae udf   (registered-read instance)
        vecs[0]  = '{1, 0, 0, 17'h11, 17'h00, 0, 1, 0, 1, 0};
        vecs[1]  = '{1, 0, 0, 17'h22, 17'h00, 0, 2, 0, 0, 0};
        vecs[2]  = '{1, 1, 0, 17'h33, 17'h11, 1, 2, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 17'h00, 17'h11, 0, 2, 0, 0, 0};
        vecs[4]  = '{0, 1, 0, 17'h00, 17'h22, 1, 1, 0, 1, 0};
        vecs[5]  = '{0, 1, 0, 17'h00, 17'h33, 1, 0, 1, 1, 0};
        vecs[6]  = '{0, 1, 0, 17'h00, 17'h33, 0, 0, 1, 1, 1};
        vecs[7]  = '{1, 0, 1, 17'h44, 17'h33, 0, 0, 1, 1, 0};
        vecs[8]  = '{1, 0, 0, 17'h55, 17'h33, 0, 1, 0, 1, 0};
        vecs[9]  = '{1, 1, 0, 17'h66, 17'h55, 1, 1, 0, 1, 0};
        vecs[10] = '{0, 1, 0, 17'h00, 17'h66, 1, 0, 1, 1, 0};
        vecs[11] = '{1, 0, 0, 17'h77, 17'h66, 0, 1, 0, 1, 0};
        vecs[12] = '{0, 1, 1, 17'h00, 17'h66, 0, 0, 1, 1, 0};

        for (int i = 0; i < 13; i++) begin
            wr_en = vecs[i].wr; rd_en = vecs[i].rd; flush = vecs[i].fl; din = vecs[i].din;
            tick();
            chk($sformatf("v%0d_dout", i), s_dout, vecs[i].e_dout);
            chk($sformatf("v%0d_dv", i), s_dv, vecs[i].e_dv);
            chk($sformatf("v%0d_cnt", i), s_count, vecs[i].e_cnt);
            chk($sformatf("v%0d_empty", i), s_empty, vecs[i].e_empty);
            chk($sformatf("v%0d_ae", i), s_ae, vecs[i].e_ae);
            chk($sformatf("v%0d_udf", i), s_udf, vecs[i].e_udf);
            chk($sformatf("v%0d_ovf", i), s_ovf, 0);
        end
        idle();

        // Fill to full, flags at the thresholds
        for (int k = 1; k <= D; k++) begin
            wr_en = 1'b1; din = W'(k);
            tick();
            chk($sformatf("fill%0d_cnt", k), s_count, k);
            chk($sformatf("fill%0d_af", k), s_af, (k >= 11) ? 1 : 0);
            chk($sformatf("fill%0d_full", k), s_full, (k == 12) ? 1 : 0);
            chk($sformatf("fill%0d_fhead", k), f_dout, 1);
        end
        // Pushes while full are rejected and latch overflow
        din = 17'h1FFFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ovf_cnt", s_count, 12);
            chk("ovf_flag", s_ovf, 1);
            chk("ovf_f_flag", f_ovf, 1);
        end
        // Push+pop while full: pop accepted, push still rejected
        rd_en = 1'b1;
        tick();
        chk("fullrw_cnt", s_count, 11);
        chk("fullrw_dout", s_dout, 1);
        chk("fullrw_ovf", s_ovf, 1);
        wr_en = 1'b0;
        for (int k = 2; k <= D; k++) begin
            tick();
            chk($sformatf("drain%0d_dout", k), s_dout, k);
            chk($sformatf("drain%0d_dv", k), s_dv, 1);
            if (k < D) chk($sformatf("drain%0d_fhead", k), f_dout, k + 1);
        end
        rd_en = 1'b0;
        tick();
        chk("drain_dv_pulse", s_dv, 0);
        chk("drain_empty", s_empty, 1);
        chk("drain_ovf_sticky", s_ovf, 1);
        chk("drain_dout_hold", s_dout, 12);
        chk("drain_f_dv", f_dv, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_ovf", s_ovf, 0);

        // Steady push+pop at count 5 across pointer wrap
        q.delete();
        for (int k = 0; k < 5; k++) begin
            wr_en = 1'b1; din = W'(17'h100 + k); q.push_back(din);
            tick();
        end
        chk("wrap_pre_cnt", s_count, 5);
        rd_en = 1'b1;
        for (int j = 0; j < 20; j++) begin
            din = W'(17'h105 + j);
            e = q.pop_front();
            q.push_back(din);
            tick();
            chk($sformatf("wrap%0d_dout", j), s_dout, e);
            chk($sformatf("wrap%0d_cnt", j), s_count, 5);
            chk($sformatf("wrap%0d_fhead", j), f_dout, q[0]);
        end
        wr_en = 1'b0;
        for (int j = 0; j < 5; j++) begin
            e = q.pop_front();
            tick();
            chk($sformatf("wdrain%0d_dout", j), s_dout, e);
        end
        rd_en = 1'b0;
        tick();
        chk("wrap_empty", s_empty, 1);

        // Underflow on empty, cleared by flush
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("udf_flag", s_udf, 1);
        chk("udf_cnt", s_count, 0);
        chk("udf_dout_hold", s_dout, 17'h118);
        chk("udf_dv", s_dv, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("udf_flush", s_udf, 0);
        chk("udf_f_flush", f_udf, 0);

        // FWFT head presentation
        wr_en = 1'b1; din = 17'h00AAA;
        tick();
        wr_en = 1'b0;
        chk("fw_head", f_dout, 17'h00AAA);
        chk("fw_dv", f_dv, 1);
        chk("fw_std_dv", s_dv, 0);
        tick();
        chk("fw_hold_dv", f_dv, 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("fw_ack_dv", f_dv, 0);
        chk("fw_ack_empty", f_empty, 1);
        chk("fw_std_dout", s_dout, 17'h00AAA);
        wr_en = 1'b1; din = 17'h0B01;
        tick();
        din = 17'h0B02;
        tick();
        wr_en = 1'b0;
        chk("fw_head1", f_dout, 17'h0B01);
        rd_en = 1'b1;
        tick();
        chk("fw_head2", f_dout, 17'h0B02);
        wr_en = 1'b1; din = 17'h0B03;
        tick();
        wr_en = 1'b0;
        chk("fw_rw_head", f_dout, 17'h0B03);
        chk("fw_rw_cnt", f_count, 1);
        tick();
        rd_en = 1'b0;
        chk("fw_last_dv", f_dv, 0);

        // Reset mid-operation with a concurrent push
        for (int k = 0; k < 7; k++) begin
            wr_en = 1'b1; din = W'(17'hC00 + k);
            tick();
        end
        chk("pre_rst_cnt", s_count, 7);
        rst = 1'b1; din = 17'h0DDD;
        tick();
        rst = 1'b0; wr_en = 1'b0;
        chk("mrst_cnt", s_count, 0);
        chk("mrst_empty", s_empty, 1);
        chk("mrst_ae", s_ae, 1);
        chk("mrst_dout", s_dout, 0);
        chk("mrst_f_dv", f_dv, 0);
        wr_en = 1'b1; din = 17'h05A5;
        tick();
        wr_en = 1'b0;
        chk("mrst_f_head", f_dout, 17'h05A5);
        chk("mrst_cnt1", s_count, 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("mrst_pop", s_dout, 17'h05A5);
        chk("mrst_pop_dv", s_dv, 1);
        chk("mrst_pop_empty", s_empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/npu_stream_fifo.md
Name: npu_stream_fifo

Overview:
Parametrised synchronous FIFO, the successor of the operand/result buffer between the NPU controller and the NxN systolic array.
Adds generic width/depth, a first-word-fall-through (FWFT) mode, occupancy output, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.
Simultaneous push and pop are handled exactly; flags carry no one-cycle lag.

Parameters:
N, 2, array dimension; used only for defaults
M, 3, operations buffered; used only for defaults
WIDTH, 15+N, data word width in bits
DEPTH, 2*N*M, number of entries; any integer >= 2, power of two not required
FWFT, 0, 0 = registered-read mode, 1 = first-word-fall-through mode
AF_THRESH, DEPTH-1, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  push request
din  in  WIDTH  push data
rd_en  in  1  pop request (FWFT: acknowledge of the current head)
flush  in  1  synchronous clear of contents
dout  out  WIDTH  read data
dout_valid  out  1  dout holds a valid word
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_empty  out  1  count <= AE_THRESH
almost_full  out  1  count >= AF_THRESH
count  out  $clog2(DEPTH+1)  current occupancy
overflow  out  1  sticky: a push was attempted while full
underflow  out  1  sticky: a pop was attempted while empty

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst; no async reset anywhere.
- Reset values:
  - Pointers = 0, count = 0, empty = 1, full = 0.
  - almost_empty = 1, almost_full = 0.
  - dout = 0, dout_valid = 0, overflow = 0, underflow = 0.
  - Memory contents are not reset.
- Accept rules, evaluated on registered state at the clock edge:
  - push_ok = wr_en & ~full
  - pop_ok = rd_en & ~empty
- Simultaneous push_ok and pop_ok: count unchanged, both pointers advance. Each event alone moves count by exactly +1 or -1.
- wr_en while full: push rejected, memory and write pointer unchanged, overflow <= 1.
  - This applies even when rd_en is also high: no pass-through when full.
- rd_en while empty: no state change except underflow <= 1.
- Pointers range 0..DEPTH-1 and wrap to 0 after DEPTH-1. Explicit compare, no reliance on power-of-two overflow.
- empty, full, almost_* and count are all decoded from the registered count. They are valid in the cycle after the accepting edge.
- FWFT=0:
  - pop_ok registers mem[rd_ptr] into dout at the edge; dout_valid = 1 for that single following cycle, else 0.
  - dout holds its last value when no pop occurs.
- FWFT=1:
  - dout = mem[rd_ptr] whenever ~empty; dout_valid = ~empty.
  - rd_en acknowledges the head. The next entry (or the simultaneously written word, if the FIFO held one entry) appears the cycle after.
  - A word written to an empty FIFO appears on dout the cycle after its push.
- flush (rst has priority over flush):
  - Pointers and count go to 0, dout_valid goes to 0, overflow and underflow are cleared.
  - Any wr_en/rd_en in the same cycle is ignored and raises no error.
- Reset asserted mid-operation discards all contents. The first push after reset lands in entry 0.
- Parameter legality (DEPTH >= 2, thresholds in range) is checked by an elaboration-time assertion.

Decomposition:
- Package npu_fifo_pkg holds:
  - the function fifo_cnt_w(depth) = $clog2(depth+1)
  - localparams FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1
- One sub-module, npu_fifo_mem: simple dual-port WIDTH x DEPTH register array with one write port and one asynchronous read port. Read-mode logic stays in the top.

Test Plan:
- Defaults (WIDTH=17, DEPTH=12, FWFT=0): push 0x00001..0x0000C -> full=1 and count=12 the cycle after the 12th push, almost_full=1 from count=11; then 12 pops -> dout 0x00001..0x0000C in order, each with a one-cycle dout_valid pulse; empty=1 after the last pop.
- Fill to 12, hold wr_en=1 with din=0x1FFFF -> push rejected, overflow=1 and sticky; pop all -> 0x1FFFF never appears.
- Hold count=5, drive wr_en=rd_en=1 for 20 cycles -> count stays 5, data order preserved across pointer wrap (rd_ptr passes 11->0).
- On empty, rd_en=1 -> underflow=1, count=0, dout unchanged; then flush=1 -> underflow=0.
- FWFT=1: push 0x00AAA to empty -> next cycle dout=0x00AAA, dout_valid=1 with no rd_en; rd_en=1 -> dout_valid=0 the following cycle.
- Push 7 words, then assert rst=1 for one cycle alongside wr_en=1 -> count=0, empty=1, almost_empty=1; subsequent push/pop returns the new word only.
